capture_ctrl: RTL and testbench

Capture sequencer for the scope front end. It takes a run command, fills the sample RAM with pre-trigger data, and then drives `armed` to the five per-channel trigger blocks. It qualifies their combined `ChxTrig` outputs, counts post-trigger samples, and hands a finished circular capture to the readout side along with the address of its last sample. It sits between the command/UART layer and the sample RAM/trigger datapath.

---
 rtl/capture_pkg.sv | 16 +
 rtl/wrap_cnt.sv | 28 ++
 rtl/capture_ctrl.sv | 156 +++++++++++++++
 tb/tb_capture_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/capture_pkg.sv
// Shared types and defaults for the scope capture sequencer.
package capture_pkg;

  localparam int DEF_DEPTH = 384;
  localparam int DEF_AW    = 9;
  localparam int NUM_CH    = 5;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    ARMED,
    POST,
    DONE
  } cap_state_t;

endpackage

// File: rtl/wrap_cnt.sv
// Modulo-DEPTH address counter: clear has priority over increment,
// and the count wraps from DEPTH-1 straight back to 0.
module wrap_cnt
  import capture_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          inc,
  output logic [AW-1:0] cnt
);

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= (cnt == LAST) ? '0 : cnt + AW'(1);
    end
  end

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: fills pre-trigger samples, arms the channel triggers,
// counts post-trigger samples and reports the last written address in DONE.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              run,
  input  logic              stop,
  input  logic [AW-1:0]     trig_pos,
  input  logic              cap_en,
  input  logic [NUM_CH-1:0] ch_trig,
  input  logic              cap_ack,
  output logic              armed,
  output logic              we,
  output logic [AW-1:0]     waddr,
  output logic [AW-1:0]     trig_addr,
  output logic              triggered,
  output logic              capture_done
);

  localparam logic [AW-1:0] LAST     = AW'(DEPTH - 1);
  localparam logic [AW:0]   LAST_EXT = (AW + 1)'(DEPTH - 1);

  cap_state_t    state, state_d;
  logic [AW-1:0] smpl_cnt, smpl_cnt_d;
  logic [AW-1:0] post_cnt, post_cnt_d;
  logic [AW-1:0] trig_pos_c, trig_pos_c_d;
  logic [AW-1:0] trig_addr_d;
  logic          armed_d, triggered_d, capture_done_d;
  logic          waddr_clr;
  logic          trig;
  logic          writing;
  logic [AW:0]   fill_sum;

  assign trig     = &ch_trig;
  assign writing  = (state == FILL) || (state == ARMED) || (state == POST);
  assign we       = cap_en & writing & ~stop;
  assign fill_sum = {1'b0, smpl_cnt} + {1'b0, trig_pos_c};

  wrap_cnt #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_waddr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (waddr_clr),
    .inc   (we),
    .cnt   (waddr)
  );

  always_comb begin
    state_d        = state;
    smpl_cnt_d     = smpl_cnt;
    post_cnt_d     = post_cnt;
    trig_pos_c_d   = trig_pos_c;
    armed_d        = armed;
    triggered_d    = triggered;
    capture_done_d = capture_done;
    waddr_clr      = 1'b0;
    // Tracks the most recent write so DONE holds the final sample address.
    trig_addr_d    = we ? waddr : trig_addr;

    case (state)
      IDLE: begin
        if (run) begin
          state_d      = FILL;
          waddr_clr    = 1'b1;
          smpl_cnt_d   = '0;
          post_cnt_d   = '0;
          triggered_d  = 1'b0;
          trig_pos_c_d = (trig_pos > LAST) ? LAST : trig_pos;
        end
      end
      FILL: begin
        if (we) begin
          smpl_cnt_d = smpl_cnt + AW'(1);
          if (fill_sum == LAST_EXT) begin
            armed_d = 1'b1;
            state_d = ARMED;
          end
        end
      end
      ARMED: begin
        if (trig) begin
          triggered_d = 1'b1;
          if (trig_pos_c == '0) begin
            state_d        = DONE;
            armed_d        = 1'b0;
            capture_done_d = 1'b1;
          end else begin
            state_d = POST;
          end
        end
      end
      POST: begin
        if (we) begin
          post_cnt_d = post_cnt + AW'(1);
          if (post_cnt == trig_pos_c - AW'(1)) begin
            state_d        = DONE;
            armed_d        = 1'b0;
            capture_done_d = 1'b1;
          end
        end
      end
      DONE: begin
        if (cap_ack) begin
          state_d        = IDLE;
          triggered_d    = 1'b0;
          capture_done_d = 1'b0;
          trig_addr_d    = '0;
          waddr_clr      = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over every other event and leaves IDLE with clean outputs.
    if (stop) begin
      state_d        = IDLE;
      armed_d        = 1'b0;
      triggered_d    = 1'b0;
      capture_done_d = 1'b0;
      trig_addr_d    = '0;
      waddr_clr      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      smpl_cnt     <= '0;
      post_cnt     <= '0;
      trig_pos_c   <= '0;
      armed        <= 1'b0;
      triggered    <= 1'b0;
      capture_done <= 1'b0;
      trig_addr    <= '0;
    end else begin
      state        <= state_d;
      smpl_cnt     <= smpl_cnt_d;
      post_cnt     <= post_cnt_d;
      trig_pos_c   <= trig_pos_c_d;
      armed        <= armed_d;
      triggered    <= triggered_d;
      capture_done <= capture_done_d;
      trig_addr    <= trig_addr_d;
    end
  end

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl: vector table for short sequences plus
// hand-written long captures (fill/arm/post, zero post, clamp with sparse strobes).
module tb_capture_ctrl;

  localparam int DEPTH = 384;
  localparam int AW    = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          run = 1'b0;
  logic          stop = 1'b0;
  logic [AW-1:0] trig_pos = '0;
  logic          cap_en = 1'b0;
  logic [4:0]    ch_trig = '0;
  logic          cap_ack = 1'b0;
  logic          armed, we, triggered, capture_done;
  logic [AW-1:0] waddr, trig_addr;

  int checks = 0;
  int errors = 0;
  int n, seen, n_pre, n_arm, n_post, n_hi, n_gap, prev_wa;

  typedef struct {
    logic          run, stop, cap_en, cap_ack;
    logic [4:0]    ch_trig;
    logic [AW-1:0] tpos;
    logic          e_we, e_armed, e_trg, e_done;
    logic [AW-1:0] e_waddr;
  } vec_t;

  vec_t tbl[16];

  capture_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .stop         (stop),
    .trig_pos     (trig_pos),
    .cap_en       (cap_en),
    .ch_trig      (ch_trig),
    .cap_ack      (cap_ack),
    .armed        (armed),
    .we           (we),
    .waddr        (waddr),
    .trig_addr    (trig_addr),
    .triggered    (triggered),
    .capture_done (capture_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic ack_done();
    @(posedge clk); #1 cap_ack = 1'b1;
    @(posedge clk); #1 cap_ack = 1'b0;
  endtask

  initial begin
    //          run   stop  en    ack   ch_trig tpos     we    armed trg   done  waddr
    tbl[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 5'h1f, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    tbl[2]  = '{1'b1, 1'b0, 1'b1, 1'b0, 5'h00, 9'd500, 1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'h00, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    tbl[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 9'd0,   1'b1, 1'b0, 1'b0, 1'b0, 9'd0};
    tbl[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'h1e, 9'd0,   1'b1, 1'b1, 1'b0, 1'b0, 9'd1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 5'h1f, 9'd0,   1'b0, 1'b1, 1'b0, 1'b0, 9'd2};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 9'd0,   1'b1, 1'b1, 1'b1, 1'b0, 9'd2};
    tbl[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 5'h1f, 9'd0,   1'b0, 1'b1, 1'b1, 1'b0, 9'd3};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 5'h00, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    tbl[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'h00, 9'd5,   1'b0, 1'b0, 1'b0, 1'b0, 9'd0};
    tbl[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 9'd5,   1'b1, 1'b0, 1'b0, 1'b0, 9'd0};
    tbl[14] = '{1'b0, 1'b1, 1'b0, 1'b0, 5'h00, 9'd5,   1'b0, 1'b0, 1'b0, 1'b0, 9'd1};
    tbl[15] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'h00, 9'd0,   1'b0, 1'b0, 1'b0, 1'b0, 9'd0};

    // Reset and idle with cap_en toggling
    repeat (2) @(negedge clk);
    chk("rst_armed", armed, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_trig_addr", trig_addr, 0);
    chk("rst_triggered", triggered, 0);
    chk("rst_done", capture_done, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1 cap_en = (i % 2 == 0);
      @(negedge clk);
      chk($sformatf("idle%0d_we", i), we, 0);
      chk($sformatf("idle%0d_waddr", i), waddr, 0);
      chk($sformatf("idle%0d_armed", i), armed, 0);
    end

    // Table: short capture with clamped trig_pos, stop in POST, stop vs run, restart
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      run = tbl[i].run; stop = tbl[i].stop; cap_en = tbl[i].cap_en;
      cap_ack = tbl[i].cap_ack; ch_trig = tbl[i].ch_trig; trig_pos = tbl[i].tpos;
      @(negedge clk);
      chk($sformatf("v%0d_we", i), we, tbl[i].e_we);
      chk($sformatf("v%0d_armed", i), armed, tbl[i].e_armed);
      chk($sformatf("v%0d_triggered", i), triggered, tbl[i].e_trg);
      chk($sformatf("v%0d_done", i), capture_done, tbl[i].e_done);
      chk($sformatf("v%0d_waddr", i), waddr, tbl[i].e_waddr);
    end

    // Fill, arm, trigger 50 cycles after arm, 100 post writes
    @(posedge clk); #1 run = 1'b1; stop = 1'b0; trig_pos = 9'd100; cap_en = 1'b1; ch_trig = '0;
    @(posedge clk); #1 run = 1'b0;
    n = 0; seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (armed) begin seen = 1; break; end
      if (we) n++;
    end
    chk("a_arm_seen", seen, 1);
    chk("a_pre_writes", n, 284);
    repeat (49) @(posedge clk);
    #1 ch_trig = 5'h1f;
    @(negedge clk);
    chk("a_trig_waddr", waddr, 333);
    chk("a_trig_cycle_triggered", triggered, 0);
    @(posedge clk); #1 ch_trig = '0;
    n = 0; seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (i == 0) chk("a_triggered_next", triggered, 1);
      if (capture_done) begin seen = 1; break; end
      if (we) n++;
    end
    chk("a_done_seen", seen, 1);
    chk("a_post_writes", n, 100);
    chk("a_trig_addr", trig_addr, 49);
    chk("a_done_armed", armed, 0);
    chk("a_done_we", we, 0);
    chk("a_done_triggered", triggered, 1);
    ack_done();
    @(negedge clk);
    chk("a_ack_done", capture_done, 0);
    chk("a_ack_waddr", waddr, 0);
    chk("a_ack_triggered", triggered, 0);
    chk("a_ack_we", we, 0);

    // Zero post-trigger: trigger-cycle sample is the last one; run ignored in DONE
    @(posedge clk); #1 run = 1'b1; trig_pos = 9'd0; cap_en = 1'b1;
    @(posedge clk); #1 run = 1'b0;
    n = 0; seen = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (armed) begin seen = 1; break; end
      if (we) n++;
    end
    chk("b_arm_seen", seen, 1);
    chk("b_pre_writes", n, 384);
    chk("b_wrapped_waddr", waddr, 0);
    @(posedge clk); #1 ch_trig = 5'h1f;
    @(posedge clk); #1 ch_trig = '0; run = 1'b1;
    @(negedge clk);
    chk("b_done", capture_done, 1);
    chk("b_trig_addr", trig_addr, 1);
    chk("b_we", we, 0);
    chk("b_armed", armed, 0);
    @(posedge clk); #1 run = 1'b0;
    @(negedge clk);
    chk("b_run_ignored", capture_done, 1);
    chk("b_trig_addr_hold", trig_addr, 1);
    ack_done();

    // Clamp 500 -> 383 with cap_en every 4th cycle; ends with stop in DONE
    @(posedge clk); #1 run = 1'b1; trig_pos = 9'd500; cap_en = 1'b0; ch_trig = '0;
    n_pre = 0; n_arm = 0; n_post = 0; n_hi = 0; n_gap = 0; prev_wa = -1; seen = 0;
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk); #1 run = 1'b0; cap_en = (k % 4 == 3); ch_trig = armed ? 5'h1f : 5'h00;
      @(negedge clk);
      if (capture_done) begin seen = 1; break; end
      if (we) begin
        if (triggered) n_post++;
        else if (armed) n_arm++;
        else n_pre++;
        if (waddr >= DEPTH) n_hi++;
        if (prev_wa >= 0 && int'(waddr) != (prev_wa + 1) % DEPTH) n_gap++;
        prev_wa = waddr;
      end
    end
    chk("c_done_seen", seen, 1);
    chk("c_pre_writes", n_pre, 1);
    chk("c_armed_writes", n_arm, 0);
    chk("c_post_writes", n_post, 383);
    chk("c_addr_over_depth", n_hi, 0);
    chk("c_addr_gaps", n_gap, 0);
    chk("c_last_write", prev_wa, 383);
    chk("c_trig_addr", trig_addr, 383);
    chk("c_waddr_wrapped", waddr, 0);
    @(posedge clk); #1 cap_en = 1'b0; ch_trig = '0; stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    @(negedge clk);
    chk("c_stop_done", capture_done, 0);
    chk("c_stop_trig_addr", trig_addr, 0);

    // Asynchronous reset in the middle of FILL
    @(posedge clk); #1 run = 1'b1; trig_pos = 9'd10; cap_en = 1'b1;
    @(posedge clk); #1 run = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("r_waddr_async", waddr, 0);
    @(negedge clk);
    chk("r_we", we, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("r_idle_we", we, 0);
    chk("r_idle_armed", armed, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
